// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider (optional SEQ_DIVIDER_SIGNED_EN) with its NSubtractor datapath

module NSubtractor #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         Vout
);

    logic [N:0] wide;

    // Single wide subtraction; a borrow out of bit N-1 lands in bit N
    always_comb begin
        wide = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, Bin};
    end

    assign Diff = wide[N-1:0];
    assign Bout = wide[N];
    assign Vout = (A[N-1] ^ B[N-1]) & (A[N-1] ^ Diff[N-1]);

endmodule

module seq_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic         signed_op,
`endif
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N:0]    r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;

    logic          accept;
    logic [N-1:0]  op_a, op_b;
    logic          op_negq, op_negr;
    logic [N:0]    t;
    logic [N:0]    diff;
    logic          bout;
    logic          sub_vout_unused;
    logic          r_top_unused;
    logic [N-1:0]  q_next;
    logic [N:0]    r_next;

    // start is only honoured outside RUN; a request mid-operation is dropped
    assign accept = start && (state_q != S_RUN);

    // R never exceeds D after a restoring step, so its top bit feeds nothing
    assign r_top_unused = r_q[N];

    NSubtractor #(.N(N + 1)) u_sub (
        .A    (t),
        .B    ({1'b0, d_q}),
        .Bin  (1'b0),
        .Diff (diff),
        .Bout (bout),
        .Vout (sub_vout_unused)
    );

    // Operand conditioning: magnitudes and result sign flags taken at accept
    always_comb begin
        op_a    = dividend;
        op_b    = divisor;
        op_negq = 1'b0;
        op_negr = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (signed_op) begin
            if (dividend[N-1]) op_a = -dividend;
            if (divisor[N-1])  op_b = -divisor;
            op_negq = dividend[N-1] ^ divisor[N-1];
            op_negr = dividend[N-1];
        end
`endif
    end

    // One restoring step: shift in the next dividend bit, keep the difference if no borrow
    always_comb begin
        t      = {r_q[N-1:0], q_q[N-1]};
        q_next = {q_q[N-2:0], ~bout};
        r_next = bout ? t : diff;
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        if (accept) begin
            q_d    = op_a;
            d_d    = op_b;
            r_d    = '0;
            cnt_d  = CNT_INIT;
            negq_d = op_negq;
            negr_d = op_negr;
            if (divisor == '0) begin
                state_d = S_DONE;
                quo_d   = '1;
                rem_d   = dividend;
                dbz_d   = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    q_d   = q_next;
                    r_d   = r_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        quo_d   = negq_q ? -q_next : q_next;
                        rem_d   = negr_q ? -r_next[N-1:0] : r_next[N-1:0];
                        dbz_d   = 1'b0;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider

module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic         signed_op;
`endif
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Drive a start pulse right now (caller sits at a negedge)
    task automatic issue_now(input logic [N-1:0] a, input logic [N-1:0] b, input bit so,
                             input logic [N-1:0] eq, input logic [N-1:0] er, input bit edbz,
                             input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = so;
`else
        if (so) $display("signed op requested in unsigned build");
`endif
        start    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.due = cyc + 1 + ((b == '0) ? 0 : N);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input bit so,
                         input logic [N-1:0] eq, input logic [N-1:0] er, input bit edbz,
                         input bit push);
        @(negedge clk);
        issue_now(a, b, so, eq, er, edbz, push);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);

        // 100 / 7, busy right after accept
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_idle();

        // back-to-back with start held in the DONE cycle
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
        check("b2b_first_done_seen", 64'(done), 64'd1);
        issue_now(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1);
        wait_idle();

        // divide by zero
        issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
        wait_idle();

        // start during RUN is ignored
        issue(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // small-dividend boundaries
        issue(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        wait_idle();
        issue(32'd3, 32'd7, 1'b0, 32'd0, 32'd3, 1'b0, 1'b1);
        wait_idle();

        // reset in the middle of 1000 / 3
        issue(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_q", 64'(quotient), 64'd0);
        check("midrst_r", 64'(remainder), 64'd0);
        check("midrst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        issue(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 1'b1);
        wait_idle();

`ifdef SEQ_DIVIDER_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_idle();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);
        wait_idle();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b1);
        wait_idle();
        issue(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider for the CPU execute stage.
- Sits directly downstream of the team's N-bit subtractor (NSubtractor) and instantiates it as its only arithmetic datapath.
- Each cycle it consumes the subtractor's Diff and Bout to perform one restoring-division step.
- Results go to the register writeback path with a start/busy/done handshake.

Parameters:
- N, 32, operand width in bits; quotient and remainder are also N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request a division; sampled only when accepting (see Behaviour)
- dividend  input  N  numerator; captured on accept
- divisor  input  N  denominator; captured on accept
- busy  output  1  high while state is RUN or DONE
- done  output  1  one-cycle pulse; quotient/remainder valid in that cycle
- quotient  output  N  registered result; held until the next accept
- remainder  output  N  registered result; held until the next accept
- div_by_zero  output  1  registered; high with done when divisor was 0; held like the results

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low: when rst_n=0 at a rising edge, state goes to IDLE and busy, done, quotient, remainder and div_by_zero all go to 0. Reset wins over start and over an in-progress operation; a partial result is discarded.
- States: IDLE, RUN, DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE; start in RUN is ignored with no side effects. On accept:
  - capture dividend into Q register and divisor into D register; clear partial remainder R (N+1 bits); load iteration counter with N-1;
  - if divisor==0, go to DONE; otherwise go to RUN.
- RUN step, one per cycle:
  - T = {R[N-1:0], Q[N-1]};
  - subtractor instance #(N+1) computes T - {1'b0,D} with Bin=0;
  - Bout=0: R=Diff, Q={Q[N-2:0],1}; Bout=1: R=T, Q={Q[N-2:0],0};
  - Vout is unused.
  - Counter decrements each step. When the step runs with counter==0, register quotient=Q_next and remainder=R_next[N-1:0], clear div_by_zero, go to DONE.
- Latency: accept at edge E0; steps at edges E1..EN; done=1 during the cycle after EN, i.e. N+1 cycles after E0 (33 for N=32).
- Divide by zero: accept at E0 goes straight to DONE. Registers quotient={N{1}}, remainder=dividend, div_by_zero=1. done is high during the cycle after E0.
- DONE lasts exactly one cycle with done=1.
  - Next edge: IDLE if start=0.
  - If start=1, accept the new operation (back-to-back, no idle bubble). done returns to 0 while the outputs keep their old values until the new results register.
- Operands are unsigned; no overflow is possible.
- Input changes on dividend or divisor after accept have no effect.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - adds input port signed_op (1 bit), sampled on accept;
  - if signed_op=1, operands are two's complement: magnitudes are taken at accept, the same N-step core runs, and signs are fixed up when the result registers;
  - quotient truncates toward zero; remainder takes the dividend's sign;
  - most-negative / -1 gives quotient=most-negative, remainder=0, div_by_zero=0;
  - x/0 gives quotient={N{1}}, remainder=dividend;
  - latency is unchanged.
- When undefined: no signed_op port; unsigned only.

Test Plan:
- Reset low 2 cycles, then release -> all outputs 0, busy=0.
- 100/7, start pulse -> busy the next cycle; done at cycle 33 after accept; quotient=14, remainder=2, div_by_zero=0.
- 0xFFFFFFFF/1 immediately followed by 0xFFFFFFFF/0xFFFFFFFE with start held high in the DONE cycle -> first result q=0xFFFFFFFF, r=0. Second done 33 cycles later: q=1, r=1.
- 5/0 -> done 1 cycle after accept; q=0xFFFFFFFF, r=5, div_by_zero=1. Start asserted during a RUN of 10/3 -> ignored; q=3, r=1.
- Reset asserted at step 10 of 1000/3 -> next cycle IDLE, outputs 0. A new 9/4 then gives q=2, r=1.
- SEQ_DIVIDER_SIGNED_EN defined, signed_op=1:
  - -7/2 -> q=-3, r=-1;
  - 7/-2 -> q=-3, r=1;
  - 0x80000000/-1 -> q=0x80000000, r=0;
  - signed_op=0 with 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
